// File: rtl/counter_drv_pkg.sv
// Shared types and default widths for the counter command driver slice.
package counter_drv_pkg;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = 8;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    LOAD = 2'b01,
    UP   = 2'b10,
    DOWN = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    DONE  = 2'b10
  } drv_state_e;
endpackage

// File: rtl/counter_cmd_driver_if.sv
// Command handshake between the test/control sequencer and the counter driver.
interface counter_cmd_driver_if
  import counter_drv_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W,
  parameter int unsigned LEN_W = counter_drv_pkg::LEN_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_arg, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, cmd_len, output cmd_ready);
endinterface

// File: rtl/counter_shadow_model.sv
// Shadow copy of the counter plus registered comparison against its feedback.
module counter_shadow_model
  import counter_drv_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic             en,
  input  logic             updwn,
  input  logic [WIDTH-1:0] datain,
  input  logic [WIDTH-1:0] fb_count,
  input  logic             err_clr,
  output logic [WIDTH-1:0] exp_count,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             err_sticky
);

  // Same priority as the counter: load beats count, wrap is modulo 2^WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_count <= '0;
      exp_valid <= 1'b0;
    end else if (ld_en) begin
      exp_count <= datain;
      exp_valid <= 1'b1;
    end else if (en) begin
      exp_count <= updwn ? exp_count + WIDTH'(1) : exp_count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      mismatch <= exp_valid && (fb_count != exp_count);
      if (mismatch)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_cmd_driver.sv
// Turns HOLD/LOAD/UP/DOWN commands into cycle-exact counter drive and checks the result.
module counter_cmd_driver
  import counter_drv_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W,
  parameter int unsigned LEN_W = counter_drv_pkg::LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_cmd_driver_if.slave  cmd,
  output logic                 ld_en,
  output logic                 en,
  output logic                 updwn,
  output logic [WIDTH-1:0]     datain,
  input  logic [WIDTH-1:0]     fb_count,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     exp_count,
  output logic                 exp_valid,
  output logic                 mismatch,
  output logic                 err_sticky,
  input  logic                 err_clr
);

  drv_state_e       state;
  logic [LEN_W-1:0] rem;

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // rem counts drive cycles still to come after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      ld_en  <= 1'b0;
      en     <= 1'b0;
      updwn  <= 1'b0;
      datain <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            if (cmd.cmd_op == LOAD) begin
              state  <= DRIVE;
              rem    <= '0;
              ld_en  <= 1'b1;
              datain <= cmd.cmd_arg;
            end else if (cmd.cmd_len == '0) begin
              state <= DONE;
            end else begin
              state <= DRIVE;
              rem   <= cmd.cmd_len - 1'b1;
              en    <= (cmd.cmd_op != HOLD);
              if (cmd.cmd_op != HOLD)
                updwn <= (cmd.cmd_op == UP);
            end
          end
        end
        DRIVE: begin
          if (rem == '0) begin
            state <= DONE;
            ld_en <= 1'b0;
            en    <= 1'b0;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  counter_shadow_model #(.WIDTH(WIDTH)) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_en      (ld_en),
    .en         (en),
    .updwn      (updwn),
    .datain     (datain),
    .fb_count   (fb_count),
    .err_clr    (err_clr),
    .exp_count  (exp_count),
    .exp_valid  (exp_valid),
    .mismatch   (mismatch),
    .err_sticky (err_sticky)
  );

endmodule

// File: tb/tb_counter_cmd_driver.sv
// Directed plus randomized bench for counter_cmd_driver with a behavioural counter.
module tb_counter_cmd_driver;
  import counter_drv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_en, en, updwn, busy, done, exp_valid, mismatch, err_sticky;
  logic       err_clr = 1'b0;
  logic [7:0] datain, exp_count, fb_count;
  logic [7:0] cnt = 8'h00;
  logic       force_fb = 1'b0;

  logic [7:0] model = 8'h00;
  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  counter_cmd_driver_if #(.WIDTH(8), .LEN_W(8)) cif ();

  counter_cmd_driver #(.WIDTH(8), .LEN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cif),
    .ld_en      (ld_en),
    .en         (en),
    .updwn      (updwn),
    .datain     (datain),
    .fb_count   (fb_count),
    .busy       (busy),
    .done       (done),
    .exp_count  (exp_count),
    .exp_valid  (exp_valid),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // The counter under control: no reset, load over count.
  always @(posedge clk) begin
    if (ld_en) cnt <= datain;
    else if (en) cnt <= updwn ? cnt + 8'd1 : cnt - 8'd1;
  end
  assign fb_count = force_fb ? 8'h00 : cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int unsigned t = 0;
    while (!cif.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(tag, (t < 50), 1);
  endtask

  // Called at a negedge; returns at the negedge one cycle after DONE.
  task automatic run_cmd(input cmd_op_e op, input logic [7:0] arg, input logic [7:0] len);
    int unsigned n;
    n = (op == LOAD) ? 1 : int'(len);
    cif.cmd_op = op; cif.cmd_arg = arg; cif.cmd_len = len; cif.cmd_valid = 1'b1;
    wait_ready("accept_timeout");
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    cif.cmd_op = cmd_op_e'($urandom_range(0, 3));
    cif.cmd_arg = 8'($urandom);
    cif.cmd_len = 8'($urandom);
    for (int unsigned i = 0; i < n; i++) begin
      chk("drv_ld_en", ld_en, (op == LOAD));
      chk("drv_en", en, (op == UP || op == DOWN));
      if (op == LOAD) chk("drv_datain", datain, arg);
      if (op == UP || op == DOWN) chk("drv_updwn", updwn, (op == UP));
      chk("drv_busy", busy, 1);
      chk("drv_done", done, 0);
      @(negedge clk);
      case (op)
        LOAD:    model = arg;
        UP:      model = model + 8'd1;
        DOWN:    model = model - 8'd1;
        default: ;
      endcase
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 1);
    chk("end_ld_en", ld_en, 0);
    chk("end_en", en, 0);
    chk("end_exp_count", exp_count, model);
    chk("end_fb_count", fb_count, model);
    chk("end_exp_valid", exp_valid, 1);
    chk("end_mismatch", mismatch, 0);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_ready", cif.cmd_ready, 1);
    chk("post_sticky", err_sticky, 0);
  endtask

  cmd_op_e    q_op  [10];
  logic [7:0] q_arg [10];
  logic [7:0] q_len [10];

  initial begin
    int unsigned cyc, last_acc, idx, done_cnt, en_cnt, ld_cnt, exp_en, exp_ld, t;
    cif.cmd_valid = 1'b0;
    cif.cmd_op = HOLD;
    cif.cmd_arg = 8'h00;
    cif.cmd_len = 8'h00;

    // Reset state
    @(negedge clk);
    chk("rst_ld_en", ld_en, 0);
    chk("rst_en", en, 0);
    chk("rst_datain", datain, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exp_valid", exp_valid, 0);
    chk("rst_exp_count", exp_count, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(LOAD, 8'h10, 8'd0);
    run_cmd(UP, 8'h00, 8'd5);
    chk("up5_result", cnt, 8'h15);
    run_cmd(LOAD, 8'hFE, 8'd7);
    run_cmd(UP, 8'h00, 8'd3);
    chk("wrap_up", exp_count, 8'h01);
    run_cmd(LOAD, 8'h01, 8'd0);
    run_cmd(DOWN, 8'h00, 8'd2);
    chk("wrap_down", exp_count, 8'hFF);
    run_cmd(LOAD, 8'h33, 8'd0);
    run_cmd(HOLD, 8'h00, 8'd4);
    chk("hold_result", cnt, 8'h33);
    run_cmd(UP, 8'h00, 8'd0);
    chk("up0_result", exp_count, 8'h33);

    // Back-to-back with cmd_valid held high
    q_op[0] = LOAD; q_arg[0] = 8'($urandom); q_len[0] = 8'd0;
    for (int unsigned i = 1; i < 10; i++) begin
      q_op[i]  = cmd_op_e'($urandom_range(0, 3));
      q_arg[i] = 8'($urandom);
      q_len[i] = 8'($urandom_range(0, 6));
    end
    exp_en = 0; exp_ld = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      case (q_op[i])
        LOAD: begin model = q_arg[i]; exp_ld++; end
        UP:   begin model = model + q_len[i]; exp_en += q_len[i]; end
        DOWN: begin model = model - q_len[i]; exp_en += q_len[i]; end
        default: ;
      endcase
    end
    cyc = 0; last_acc = 0; idx = 0; done_cnt = 0; en_cnt = 0; ld_cnt = 0;
    while (cyc < 2000) begin
      if (done) done_cnt++;
      if (en) en_cnt++;
      if (ld_en) ld_cnt++;
      if (cif.cmd_ready) begin
        if (idx == 10) begin
          cif.cmd_valid = 1'b0;
          break;
        end
        if (idx > 0)
          chk("b2b_spacing", cyc - last_acc,
              ((q_op[idx-1] == LOAD) ? 1 : int'(q_len[idx-1])) + 2);
        cif.cmd_op = q_op[idx]; cif.cmd_arg = q_arg[idx]; cif.cmd_len = q_len[idx];
        cif.cmd_valid = 1'b1;
        last_acc = cyc;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    cif.cmd_valid = 1'b0;
    chk("b2b_timeout", (cyc < 2000), 1);
    chk("b2b_done_cnt", done_cnt, 10);
    chk("b2b_en_cycles", en_cnt, exp_en);
    chk("b2b_ld_cycles", ld_cnt, exp_ld);
    chk("b2b_exp_count", exp_count, model);
    chk("b2b_fb_count", fb_count, model);
    chk("b2b_sticky", err_sticky, 0);

    // Fault injection
    run_cmd(LOAD, 8'h20, 8'd0);
    force_fb = 1'b1;
    @(negedge clk);
    chk("fault_mismatch", mismatch, 1);
    @(negedge clk);
    chk("fault_sticky", err_sticky, 1);
    force_fb = 1'b0;
    @(negedge clk);
    chk("fault_release_mm", mismatch, 0);
    chk("fault_sticky_hold", err_sticky, 1);
    @(negedge clk);
    chk("fault_sticky_hold2", err_sticky, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("fault_cleared", err_sticky, 0);

    // Reset in the middle of UP len=10
    cif.cmd_op = UP; cif.cmd_arg = 8'h00; cif.cmd_len = 8'd10; cif.cmd_valid = 1'b1;
    wait_ready("mid_accept_timeout");
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_en_before", en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ld_en", ld_en, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_updwn", updwn, 0);
    chk("mid_rst_datain", datain, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mismatch", mismatch, 0);
    chk("mid_rst_sticky", err_sticky, 0);
    chk("mid_rst_exp_valid", exp_valid, 0);
    chk("mid_rst_exp_count", exp_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) t++;
    end
    chk("mid_no_done", t, 0);
    chk("mid_ready", cif.cmd_ready, 1);
    chk("mid_exp_valid", exp_valid, 0);
    run_cmd(LOAD, 8'h5A, 8'd0);
    run_cmd(DOWN, 8'h00, 8'd3);
    chk("post_rst_result", exp_count, 8'h57);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
